// File: rtl/key_expand_serial.sv
// AES-128 round-key generator: derives the next round key from the current one with one shared S-box.
// Latency: key_start in cycle 0 -> SubWord in cycles 1-4 -> combine in cycle 5 -> new key and key_valid in cycle 6.
// Backpressure: none. A key_start while busy is dropped and sets sticky overrun. load always wins and aborts.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load, key_in          load key_in as round key 0 (highest priority, aborts an expansion)
//   key_start, key_RC     request the next round key using round constant {RC,00,00,00}
//   round_key             current round key (registered, only changes on load or completed step)
//   key_valid             one-cycle pulse after round_key changes
//   busy                  expansion in progress
//   overrun               sticky: key_start arrived while busy; cleared by load or reset
module key_expand_serial (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [127:0] key_in,
    input  logic         key_start,
    input  logic [31:0]  key_RC,
    output logic [127:0] round_key,
    output logic         key_valid,
    output logic         busy,
    output logic         overrun
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SUB     = 2'd1;
    localparam logic [1:0] COMBINE = 2'd2;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        sbox = SBOX_TABLE[(255 - int'(a)) * 8 +: 8];
    endfunction

    logic [1:0]  state;
    logic [1:0]  idx;
    logic [31:0] temp;
    logic [31:0] rc;
    logic [31:0] temp_next;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t, n0, n1, n2, n3;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    // One byte of the rotated word goes through the S-box per SUB cycle; byte 0 is the MSB byte.
    always_comb begin
        temp_next = temp;
        temp_next[(3 - int'(idx)) * 8 +: 8] = sbox(temp[(3 - int'(idx)) * 8 +: 8]);
    end

    // Chained XOR of the key schedule: each new word folds in the previous new word.
    assign t  = temp ^ rc;
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            temp      <= 32'd0;
            rc        <= 32'd0;
            round_key <= 128'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (load) begin
                // Load overrides everything, including a key_start in the same cycle.
                round_key <= key_in;
                key_valid <= 1'b1;
                state     <= IDLE;
                idx       <= 2'd0;
                overrun   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (key_start) begin
                            rc    <= key_RC;
                            temp  <= {w3[23:0], w3[31:24]};
                            idx   <= 2'd0;
                            state <= SUB;
                        end
                    end
                    SUB: begin
                        if (key_start) overrun <= 1'b1;
                        temp <= temp_next;
                        idx  <= idx + 2'd1;
                        if (idx == 2'd3) state <= COMBINE;
                    end
                    COMBINE: begin
                        if (key_start) overrun <= 1'b1;
                        round_key <= {n0, n1, n2, n3};
                        key_valid <= 1'b1;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/key_expand_serial.md
Name: key_expand_serial

Overview:
- Round-key generator for the AES-128 encryption datapath. It sits directly downstream of the round controller and consumes that block's key_start pulse and key_RC round constant.
- On each key_start it derives the next 128-bit round key from the current one, using the FIPS-197 key schedule.
- It contains a single internal S-box ROM, so SubWord runs byte-serially over 4 cycles.
- The round key it produces feeds the AddRoundKey stage.

Parameters:
- None. AES-128 only; all widths are fixed.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle pulse; loads key_in as round key 0.
- key_in  input  128  cipher key, sampled when load=1.
- key_start  input  1  single-cycle pulse from the round controller; request the next round key.
- key_RC  input  32  round constant {RC,00,00,00}, sampled in the key_start cycle.
- round_key  output  128  current round key, registered.
- key_valid  output  1  one-cycle pulse; round_key has just been updated.
- busy  output  1  expansion in progress.
- overrun  output  1  sticky flag; key_start was received while busy.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, byte index=0.
  - round_key=0, key_valid=0, busy=0, overrun=0, temp word=0, latched RC=0.
  - A reset mid-expansion aborts it with no partial update.
- Word view: w0=round_key[127:96], w1=[95:64], w2=[63:32], w3=[31:0]. Byte 0 is the MSB byte of a word.
- FSM states: IDLE, SUB, COMBINE.
- IDLE:
  - load=1: round_key<=key_in; key_valid=1 next cycle; state stays IDLE.
  - key_start=1 (load=0):
    - latch rc<=key_RC;
    - temp<=RotWord(w3), where RotWord({a0,a1,a2,a3})={a1,a2,a3,a0};
    - idx<=0; state->SUB.
- SUB, one cycle per byte:
  - temp byte[idx] <= Sbox(temp byte[idx]).
  - idx increments 0..3; after idx=3 is written, state->COMBINE.
  - Exactly 4 cycles are spent in SUB.
- COMBINE, one cycle; t=temp^rc, then:
  - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2;
  - round_key<={n0,n1,n2,n3}; state->IDLE; key_valid=1 in the following cycle.
- Latency, with the key_start cycle as cycle 0:
  - SUB in cycles 1-4, COMBINE in cycle 5.
  - The new round_key is visible and key_valid=1 in cycle 6.
  - busy=1 in cycles 1-5 inclusive; busy=0 in IDLE.
- key_valid is registered and high for exactly 1 cycle per completed expansion or load.
- round_key holds its value between updates. No intermediate values are visible on round_key.
- Boundary conditions:
  - load while busy (SUB/COMBINE): abort the expansion. round_key<=key_in, state->IDLE, overrun<=0, key_valid pulses next cycle. Load has highest priority.
  - load and key_start in the same cycle: load wins. key_start is dropped and overrun is not set.
  - key_start while busy (no load): request ignored, expansion continues unchanged, overrun<=1 (sticky until load or reset).
  - key_RC is used only as latched in cycle 0; later changes on key_RC have no effect.
  - key_start with key_RC=0 is legal and produces a schedule step with no RC injection.
- Arithmetic is XOR only; there is no carry or wrap. The byte index is 2 bits and wraps naturally but never exceeds 3 in use.
- The S-box is a combinational 256x8 ROM holding the FIPS-197 forward S-box. There is one instance, shared across the 4 SUB cycles.

Test Plan:
- Reset check: assert reset_n=0 mid-SUB -> round_key=0, busy=0, key_valid=0, overrun=0 immediately (async).
- FIPS-197 round 1:
  - Stimulus: load key_in=2b7e151628aed2a6abf7158809cf4f3c, then key_start with key_RC=01000000.
  - Required: key_valid in cycle 6, round_key=a0fafe1788542cb123a339392a6c7605, busy=1 for exactly 5 cycles.
- Full schedule:
  - Stimulus: from the same key, 10 key_starts spaced 6 cycles apart with RC 01,02,04,08,10,20,40,80,1B,36.
  - Required: round 2 key=f2c295f27a96b9435935807a7359f67f; round 10 key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Zero key: load 0, key_start with RC=01000000 -> round_key=62636363626363636263636362636363.
- Overrun and priority:
  - key_start again in cycle 2 -> overrun=1, and the result still equals the single-request value.
  - load together with key_start -> round_key=key_in, no expansion starts, overrun unchanged by key_start.
- Abort: load with new key_in during cycle 3 of an expansion -> round_key=key_in next cycle, one key_valid pulse, busy=0, overrun cleared, no later key_valid from the aborted run.
